// File: rtl/ide_pio_pkg.sv
// ide_pio_pkg: shared definitions for the IDE PIO strobe sequencer.
//   - FSM state encodings (IDLE..RECOVER)
//   - counter widths: 8-bit phase timer, 12-bit IORDY wait counter
//   - default phase timings (PIO mode 0 at MEMCLK)
//   - latched request record and a phase-timer load helper
package ide_pio_pkg;

    localparam int PHASE_W = 8;
    localparam int WAIT_W  = 12;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_ACTIVE   = 3'd2;
    localparam logic [2:0] ST_WAIT_END = 3'd3;
    localparam logic [2:0] ST_RECOVER  = 3'd4;

    // PIO mode 0 timings in MEMCLK cycles
    localparam int unsigned DEF_T_SETUP       = 2;
    localparam int unsigned DEF_T_ACTIVE      = 8;
    localparam int unsigned DEF_T_RECOVER     = 6;
    localparam int unsigned DEF_IORDY_TIMEOUT = 1024;

    // Captured at cycle start; later changes on the bus are ignored.
    typedef struct packed {
        logic rw;      // 1 = read
        logic cs_sel;  // 0 = CS1, 1 = CS2
    } pio_req_t;

    // The timer counts down to zero inclusive, so an N-cycle phase loads N-1.
    function automatic logic [PHASE_W-1:0] phase_load(input int unsigned cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ide_pio_timing_if.sv
// ide_pio_timing_if: bus between the Zorro II side / IDE decode and the
// PIO sequencer, plus the IDE drive-side strobes.
//   master : drives decoded access, synced Z2 strobes, cs_sel, IORDY
//   slave  : the sequencer; drives CS, IOR/IOW, buffer enable, DTACK, timeout
interface ide_pio_timing_if;

    logic ide_access;
    logic as_n;
    logic ds_n;
    logic rw;
    logic cs_sel;
    logic iordy;

    logic idecs1_n;
    logic idecs2_n;
    logic ior_n;
    logic iow_n;
    logic buf_oe_n;
    logic dtack;
    logic iordy_timeout;

    modport master (
        output ide_access, as_n, ds_n, rw, cs_sel, iordy,
        input  idecs1_n, idecs2_n, ior_n, iow_n, buf_oe_n, dtack, iordy_timeout
    );

    modport slave (
        input  ide_access, as_n, ds_n, rw, cs_sel, iordy,
        output idecs1_n, idecs2_n, ior_n, iow_n, buf_oe_n, dtack, iordy_timeout
    );

endinterface

// File: rtl/ide_phase_timer.sv
// ide_phase_timer: loadable down-counter shared by SETUP/ACTIVE/RECOVER.
//   clk, reset : MEMCLK, synchronous active-high reset
//   load       : load load_val (wins over dec)
//   dec        : decrement, saturating at zero
//   zero       : count has reached zero
module ide_phase_timer
    import ide_pio_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [PHASE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ide_pio_timing.sv
// ide_pio_timing: ATA PIO strobe/timing sequencer in the MEMCLK domain.
//   clk, reset : MEMCLK, synchronous active-high reset
//   bus        : slave side of ide_pio_timing_if
//     in : ide_access, as_n, ds_n, rw, cs_sel, iordy
//     out: idecs1_n, idecs2_n, ior_n, iow_n, buf_oe_n, dtack, iordy_timeout
// Cycle: IDLE -> SETUP (CS low) -> ACTIVE (strobe low, IORDY wait)
//        -> WAIT_END (dtack until AS_n rises) -> RECOVER -> IDLE.
// All outputs are registered.
module ide_pio_timing
    import ide_pio_pkg::*;
#(
    parameter int unsigned T_SETUP       = DEF_T_SETUP,
    parameter int unsigned T_ACTIVE      = DEF_T_ACTIVE,
    parameter int unsigned T_RECOVER     = DEF_T_RECOVER,
    parameter int unsigned IORDY_TIMEOUT = DEF_IORDY_TIMEOUT
) (
    input logic             clk,
    input logic             reset,
    ide_pio_timing_if.slave bus
);

    logic [2:0]        state, state_nxt;
    pio_req_t          req_q, req_nxt;
    logic [WAIT_W-1:0] wait_q, wait_nxt;

    logic cs1_n_q, cs2_n_q, ior_n_q, iow_n_q, oe_n_q, dtack_q, tmo_q;
    logic cs1_n_nxt, cs2_n_nxt, ior_n_nxt, iow_n_nxt, oe_n_nxt, dtack_nxt, tmo_nxt;

    logic               tmr_load, tmr_dec, tmr_zero;
    logic [PHASE_W-1:0] tmr_val;

    logic start, to_recover, active_done, in_cycle_nxt;

    assign start = bus.ide_access & ~bus.as_n & ~bus.ds_n;

    ide_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt   = state;
        req_nxt     = req_q;
        wait_nxt    = wait_q;
        ior_n_nxt   = ior_n_q;
        iow_n_nxt   = iow_n_q;
        dtack_nxt   = dtack_q;
        tmo_nxt     = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_val     = '0;
        to_recover  = 1'b0;
        active_done = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    req_nxt.rw     = bus.rw;
                    req_nxt.cs_sel = bus.cs_sel;
                    wait_nxt       = '0;
                    tmr_load       = 1'b1;
                    tmr_val        = phase_load(T_SETUP);
                    state_nxt      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (bus.as_n)
                    to_recover = 1'b1;
                else if (tmr_zero) begin
                    ior_n_nxt = ~req_q.rw;
                    iow_n_nxt = req_q.rw;
                    tmr_load  = 1'b1;
                    tmr_val   = phase_load(T_ACTIVE);
                    state_nxt = ST_ACTIVE;
                end else
                    tmr_dec = 1'b1;
            end
            ST_ACTIVE: begin
                if (bus.as_n)
                    to_recover = 1'b1;
                else if (!tmr_zero)
                    tmr_dec = 1'b1;
                else if (bus.iordy)
                    active_done = 1'b1;
                else if (wait_q == WAIT_W'(IORDY_TIMEOUT)) begin
                    // Drive never came ready: finish the cycle anyway.
                    tmo_nxt     = 1'b1;
                    active_done = 1'b1;
                end else
                    wait_nxt = wait_q + 1'b1;
            end
            ST_WAIT_END: begin
                if (bus.as_n)
                    to_recover = 1'b1;
            end
            ST_RECOVER: begin
                if (tmr_zero)
                    state_nxt = ST_IDLE;
                else
                    tmr_dec = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Write data is held by CS and the buffer, so IOW can end early;
        // IOR stays low so read data remains valid through the buffer.
        if (active_done) begin
            dtack_nxt = 1'b1;
            iow_n_nxt = 1'b1;
            state_nxt = ST_WAIT_END;
        end

        // Normal end and abort share the same teardown.
        if (to_recover) begin
            ior_n_nxt = 1'b1;
            iow_n_nxt = 1'b1;
            dtack_nxt = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = phase_load(T_RECOVER);
            state_nxt = ST_RECOVER;
        end

        // CS and buffer enable follow the state, so only one CS can ever be low
        // and strobes are always inside the CS window.
        in_cycle_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_ACTIVE) ||
                       (state_nxt == ST_WAIT_END);
        cs1_n_nxt    = ~(in_cycle_nxt & ~req_nxt.cs_sel);
        cs2_n_nxt    = ~(in_cycle_nxt &  req_nxt.cs_sel);
        oe_n_nxt     = ~in_cycle_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            wait_q  <= '0;
            cs1_n_q <= 1'b1;
            cs2_n_q <= 1'b1;
            ior_n_q <= 1'b1;
            iow_n_q <= 1'b1;
            oe_n_q  <= 1'b1;
            dtack_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_q   <= req_nxt;
            wait_q  <= wait_nxt;
            cs1_n_q <= cs1_n_nxt;
            cs2_n_q <= cs2_n_nxt;
            ior_n_q <= ior_n_nxt;
            iow_n_q <= iow_n_nxt;
            oe_n_q  <= oe_n_nxt;
            dtack_q <= dtack_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    assign bus.idecs1_n      = cs1_n_q;
    assign bus.idecs2_n      = cs2_n_q;
    assign bus.ior_n         = ior_n_q;
    assign bus.iow_n         = iow_n_q;
    assign bus.buf_oe_n      = oe_n_q;
    assign bus.dtack         = dtack_q;
    assign bus.iordy_timeout = tmo_q;

endmodule

// File: tb/tb_ide_pio_timing.sv
// tb_ide_pio_timing: randomized scoreboard bench for ide_pio_timing.
// The stimulus thread plans each IDE cycle in absolute clock-edge numbers,
// pushes the expected cycle record, and drives inputs edge by edge. A
// monitor rebuilds observed cycle records from the outputs and compares.
module tb_ide_pio_timing;

    localparam int T_SU  = 2;
    localparam int T_ACT = 8;
    localparam int T_REC = 6;
    localparam int TMO   = 16;

    typedef struct {
        int cs;     // edge on which a CS goes low
        int sel;    // 1 = CS2
        int rd;     // 1 = IOR strobe
        int stb_s;  // strobe low edge, 0 = never
        int stb_e;  // strobe high edge
        int dt;     // dtack rise edge, 0 = never
        int tmo;    // iordy_timeout edge, 0 = never
        int rel;    // edge on which CS returns high
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   free_e = 0;
    bit   mon_en = 1'b1;
    exp_t q[$];

    ide_pio_timing_if bus();

    ide_pio_timing #(
        .T_SETUP       (T_SU),
        .T_ACTIVE      (T_ACT),
        .T_RECOVER     (T_REC),
        .IORDY_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // ---------------- monitor ----------------
    bit   in_txn = 1'b0;
    exp_t o;
    int   o_tmo_n;
    exp_t x;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            automatic bit any_cs = !bus.idecs1_n || !bus.idecs2_n;
            automatic bit stb    = !bus.ior_n || !bus.iow_n;
            automatic int viol   = 0;
            if (!bus.ior_n && !bus.iow_n)                    viol |= 1;
            if (!bus.idecs1_n && !bus.idecs2_n)              viol |= 2;
            if ((stb || bus.dtack || bus.iordy_timeout) && !any_cs) viol |= 4;
            if (bus.buf_oe_n == any_cs)                      viol |= 8;
            chk("invariant", viol, 0);

            if (!in_txn && any_cs) begin
                in_txn  = 1'b1;
                o.cs    = edge_n;
                o.sel   = int'(!bus.idecs2_n);
                o.rd    = 0;
                o.stb_s = 0;
                o.stb_e = 0;
                o.dt    = 0;
                o.tmo   = 0;
                o_tmo_n = 0;
            end
            if (in_txn) begin
                if (stb && o.stb_s == 0) begin
                    o.stb_s = edge_n;
                    o.rd    = int'(!bus.ior_n);
                end
                if (o.stb_s != 0 && o.stb_e == 0 && !stb) o.stb_e = edge_n;
                if (bus.dtack && o.dt == 0) o.dt = edge_n;
                if (bus.iordy_timeout) begin
                    o_tmo_n++;
                    o.tmo = edge_n;
                end
                if (!any_cs) begin
                    in_txn = 1'b0;
                    o.rel  = edge_n;
                    if (q.size() == 0) begin
                        chk("unexpected_cycle_at", o.cs, 0);
                    end else begin
                        x = q.pop_front();
                        chk("cs_edge",     o.cs,    x.cs);
                        chk("cs_sel",      o.sel,   x.sel);
                        chk("strobe_low",  o.stb_s, x.stb_s);
                        chk("strobe_high", o.stb_e, x.stb_e);
                        if (x.stb_s != 0) chk("strobe_is_read", o.rd, x.rd);
                        chk("dtack_edge",  o.dt,    x.dt);
                        chk("timeout_edge", o.tmo,  x.tmo);
                        chk("timeout_pulses", o_tmo_n, (x.tmo != 0) ? 1 : 0);
                        chk("release_edge", o.rel,  x.rel);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // gap < 0: random request delay; ab < 0: no abort, 0: random abort,
    // > 0: AS_n sampled high at cs edge + ab.
    task automatic run_txn(input bit rw, input bit sel, input int w, input int ab, input int gap);
        int   req_e, ecs, ed0, edt, ea, e;
        exp_t xe;
        req_e = edge_n + 1 + ((gap < 0) ? int'($urandom_range(0, T_REC + 3)) : gap);
        ecs   = (req_e > free_e) ? req_e : free_e;
        ed0   = ecs + T_SU + T_ACT;
        edt   = ed0 + ((w < TMO) ? w : TMO);
        if (ab > 0)       ea = ecs + ab;
        else if (ab == 0) ea = ecs + 1 + int'($urandom_range(0, edt - ecs - 1));
        else              ea = edt + int'($urandom_range(1, 3));

        xe.cs  = ecs;
        xe.sel = int'(sel);
        xe.rd  = int'(rw);
        xe.rel = ea;
        if (ab >= 0) begin
            xe.stb_s = (ea > ecs + T_SU) ? ecs + T_SU : 0;
            xe.stb_e = (xe.stb_s != 0) ? ea : 0;
            xe.dt    = 0;
            xe.tmo   = 0;
        end else begin
            xe.stb_s = ecs + T_SU;
            xe.stb_e = rw ? ea : edt;
            xe.dt    = edt;
            xe.tmo   = (w > TMO) ? edt : 0;
        end
        q.push_back(xe);

        while (edge_n < ea) begin
            e              = edge_n + 1;
            bus.as_n       = !(e >= req_e && e < ea);
            bus.ds_n       = bus.as_n;
            bus.ide_access = !bus.as_n;
            bus.iordy      = !(e >= ed0 && e < ed0 + w);
            if (e <= ecs) begin
                bus.rw     = rw;
                bus.cs_sel = sel;
            end else begin
                bus.rw     = 1'($urandom_range(0, 1));
                bus.cs_sel = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        free_e = ea + T_REC + 1;
    endtask

    // Zorro cycle to some other device: must not start an IDE cycle.
    task automatic other_access();
        int n;
        n = int'($urandom_range(2, 5));
        for (int i = 0; i < n; i++) begin
            bus.as_n = 1'b0; bus.ds_n = 1'b0; bus.ide_access = 1'b0;
            @(negedge clk);
        end
        bus.as_n = 1'b1; bus.ds_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_idecs1_n"}, int'(bus.idecs1_n), 1);
        chk({tag, "_idecs2_n"}, int'(bus.idecs2_n), 1);
        chk({tag, "_ior_n"}, int'(bus.ior_n), 1);
        chk({tag, "_iow_n"}, int'(bus.iow_n), 1);
        chk({tag, "_buf_oe_n"}, int'(bus.buf_oe_n), 1);
        chk({tag, "_dtack"}, int'(bus.dtack), 0);
        chk({tag, "_iordy_timeout"}, int'(bus.iordy_timeout), 0);
    endtask

    initial begin
        int ecs, w, pick;
        bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.ide_access = 1'b0;
        bus.rw = 1'b0; bus.cs_sel = 1'b0; bus.iordy = 1'b1;

        // reset dominates a pending request
        repeat (2) @(negedge clk);
        bus.as_n = 1'b0; bus.ds_n = 1'b0; bus.ide_access = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");
        bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.ide_access = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // directed
        run_txn(1'b1, 1'b0, 0, -1, 0);     // plain read, CS1
        run_txn(1'b0, 1'b1, 0, -1, -1);    // plain write, CS2
        run_txn(1'b1, 1'b0, 15, -1, -1);   // IORDY wait just under timeout
        run_txn(1'b0, 1'b0, 16, -1, -1);   // wait equal to timeout: still no pulse
        run_txn(1'b1, 1'b1, 40, -1, -1);   // stuck IORDY: timeout
        run_txn(1'b1, 1'b0, 0, 1, -1);     // abort in SETUP
        run_txn(1'b0, 1'b1, 0, 0, 0);      // request lands in RECOVER
        run_txn(1'b0, 1'b0, 5, T_SU + 3, -1); // abort in ACTIVE after strobe

        // randomized
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) other_access();
            pick = int'($urandom_range(0, 5));
            case (pick)
                0:       w = 0;
                1:       w = TMO - 1 + int'($urandom_range(0, 2));
                2:       w = TMO + int'($urandom_range(1, 10));
                default: w = int'($urandom_range(0, 6));
            endcase
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
                    ($urandom_range(0, 4) == 0) ? 0 : -1, -1);
        end

        // reset in ACTIVE
        @(negedge clk);
        mon_en = 1'b0;
        while (edge_n + 1 < free_e) @(negedge clk);
        bus.rw = 1'b1; bus.cs_sel = 1'b0; bus.iordy = 1'b1;
        bus.as_n = 1'b0; bus.ds_n = 1'b0; bus.ide_access = 1'b1;
        ecs = edge_n + 1;
        while (edge_n < ecs + T_SU + 2) @(negedge clk);
        chk("pre_reset_ior_n", int'(bus.ior_n), 0);
        chk("pre_reset_idecs1_n", int'(bus.idecs1_n), 0);
        reset = 1'b1;
        bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.ide_access = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle_cs1", int'(bus.idecs1_n), 1);
        bus.rw = 1'b0; bus.cs_sel = 1'b1;
        bus.as_n = 1'b0; bus.ds_n = 1'b0; bus.ide_access = 1'b1;
        @(negedge clk);
        chk("post_reset_start_cs2", int'(bus.idecs2_n), 0);
        chk("post_reset_start_cs1", int'(bus.idecs1_n), 1);
        chk("post_reset_start_oe", int'(bus.buf_oe_n), 0);
        bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.ide_access = 1'b0;
        repeat (T_REC + 3) @(negedge clk);
        chk("final_cs2_idle", int'(bus.idecs2_n), 1);

        chk("scoreboard_left", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
